// File: rtl/cpu_types_pkg.sv
// Shared execute-stage types: machine word, multiply/divide opcodes and the
// iteration count of the radix-2 multiply/divide unit.
package cpu_types_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      MD_MULT,
      MD_MULTU,
      MD_DIV,
      MD_DIVU
   } mdop_t;

   localparam int MD_STEPS = 32;

   // Magnitude of a signed operand; unsigned operands pass through unchanged.
   function automatic word_t md_mag(input word_t v, input logic is_signed);
      return (is_signed && v[31]) ? word_t'(-v) : v;
   endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU unit with the architectural HI/LO
// registers. One radix-2 step per cycle, followed by a sign fix-up cycle.
module muldiv_unit
   import cpu_types_pkg::*;
(
   input  logic  CLK,
   input  logic  RST,
   input  logic  start,
   input  mdop_t mdop,
   input  word_t a,
   input  word_t b,
   input  logic  flush,
   input  logic  hi_wen,
   input  logic  lo_wen,
   input  word_t wdat,
   output logic  busy,
   output logic  done,
   output word_t hi,
   output word_t lo
);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX
   } state_t;

   localparam logic [5:0] LAST_STEP = 6'(MD_STEPS - 1);

   state_t      r_state;
   state_t      w_state_next;
   logic [5:0]  r_cnt;
   logic [63:0] r_acc;
   word_t       r_x;        // multiplicand, or dividend shifting out MSB-first
   word_t       r_y;        // multiplier shifting out LSB-first, or divisor
   word_t       r_a_orig;
   mdop_t       r_op;
   logic        r_sa;
   logic        r_sb;
   logic        r_dz;
   word_t       r_hi;
   word_t       r_lo;
   logic        r_done;

   logic        w_launch;
   logic        w_in_signed;
   logic        w_is_mul;
   logic        w_is_signed;
   logic [32:0] w_mul_sum;
   logic [63:0] w_mul_next;
   word_t       w_rem_sh;
   logic [32:0] w_trial;
   logic [63:0] w_div_next;
   logic [63:0] w_prod;
   word_t       w_quot;
   word_t       w_rem;
   word_t       w_fix_hi;
   word_t       w_fix_lo;

   assign w_launch    = start && !flush && (r_state == IDLE);
   assign w_in_signed = (mdop == MD_MULT) || (mdop == MD_DIV);
   assign w_is_mul    = (r_op == MD_MULT) || (r_op == MD_MULTU);
   assign w_is_signed = (r_op == MD_MULT) || (r_op == MD_DIV);

   // Shift-add multiply: add into the upper half, then shift the pair right.
   assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_y[0] ? {1'b0, r_x} : 33'd0);
   assign w_mul_next = {w_mul_sum, r_acc[31:1]};

   // Restoring divide: remainder takes the next dividend bit, quotient the result bit.
   assign w_rem_sh   = {r_acc[62:32], r_x[31]};
   assign w_trial    = {1'b0, w_rem_sh} - {1'b0, r_y};
   assign w_div_next = w_trial[32] ? {w_rem_sh, r_acc[30:0], 1'b0}
                                   : {w_trial[31:0], r_acc[30:0], 1'b1};

   assign w_prod = (w_is_signed && (r_sa ^ r_sb)) ? -r_acc : r_acc;
   assign w_quot = (w_is_signed && (r_sa ^ r_sb)) ? word_t'(-r_acc[31:0]) : r_acc[31:0];
   assign w_rem  = (w_is_signed && r_sa) ? word_t'(-r_acc[63:32]) : r_acc[63:32];

   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      w_fix_hi = w_rem;
      w_fix_lo = w_quot;
      if (r_dz) begin
         w_fix_hi = r_a_orig;
         w_fix_lo = 32'hFFFF_FFFF;
      end else if (w_is_mul) begin
         w_fix_hi = w_prod[63:32];
         w_fix_lo = w_prod[31:0];
      end
   end

   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignment so all flops see pre-edge values.
      if (RST) r_state <= IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (w_launch) w_state_next = CALC;
         CALC:    if (flush) w_state_next = IDLE;
                  else if (r_cnt == LAST_STEP) w_state_next = FIX;
         FIX:     w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_cnt    <= '0;
         r_acc    <= '0;
         r_x      <= '0;
         r_y      <= '0;
         r_a_orig <= '0;
         r_op     <= MD_MULT;
         r_sa     <= 1'b0;
         r_sb     <= 1'b0;
         r_dz     <= 1'b0;
         r_hi     <= '0;
         r_lo     <= '0;
         r_done   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_launch) begin
                  r_x      <= md_mag(a, w_in_signed);
                  r_y      <= md_mag(b, w_in_signed);
                  r_a_orig <= a;
                  r_op     <= mdop;
                  r_sa     <= a[31];
                  r_sb     <= b[31];
                  r_dz     <= (b == '0);
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end else begin
                  if (hi_wen) r_hi <= wdat;
                  if (lo_wen) r_lo <= wdat;
               end
            end
            CALC: begin
               if (!flush) begin
                  r_cnt <= r_cnt + 6'd1;
                  if (w_is_mul) begin
                     r_acc <= w_mul_next;
                     r_y   <= r_y >> 1;
                  end else begin
                     r_acc <= w_div_next;
                     r_x   <= r_x << 1;
                  end
               end
            end
            FIX: begin
               if (!flush) begin
                  r_hi   <= w_fix_hi;
                  r_lo   <= w_fix_lo;
                  r_done <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign busy = (r_state != IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver queues hand-computed HI/LO
// results, a negedge monitor pops and compares them whenever done pulses.
module tb_muldiv_unit;
   import cpu_types_pkg::*;

   // Result appears 33 edges after the start edge (34 cycles counting the start cycle).
   localparam int RESULT_EDGES = 33;

   logic  CLK = 1'b0;
   logic  RST = 1'b1;
   logic  start = 1'b0;
   mdop_t mdop = MD_MULT;
   word_t a = '0;
   word_t b = '0;
   logic  flush = 1'b0;
   logic  hi_wen = 1'b0;
   logic  lo_wen = 1'b0;
   word_t wdat = '0;
   logic  busy;
   logic  done;
   word_t hi;
   word_t lo;

   muldiv_unit dut (
      .CLK    (CLK),
      .RST    (RST),
      .start  (start),
      .mdop   (mdop),
      .a      (a),
      .b      (b),
      .flush  (flush),
      .hi_wen (hi_wen),
      .lo_wen (lo_wen),
      .wdat   (wdat),
      .busy   (busy),
      .done   (done),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string name;
      word_t hi;
      word_t lo;
      int    cyc;
   } exp_t;

   typedef struct {
      string name;
      mdop_t op;
      word_t a;
      word_t b;
      word_t hi;
      word_t lo;
   } vec_t;

   exp_t sb[$];
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;

   always @(posedge CLK) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   always @(negedge CLK) begin : monitor
      exp_t e;
      if (!RST && done) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done=1 with hi=0x%08h lo=0x%08h, expected no result (cycle %0d)",
                     hi, lo, cyc);
         end else begin
            e = sb.pop_front();
            check({e.name, "_hi"}, hi, e.hi);
            check({e.name, "_lo"}, lo, e.lo);
            check({e.name, "_latency"}, 32'(cyc - e.cyc), 32'(RESULT_EDGES));
         end
      end
   end

   // Called at a negedge; returns at the negedge right after the start edge.
   task automatic launch(input mdop_t op, input word_t va, input word_t vb, output int k);
      start = 1'b1;
      mdop  = op;
      a     = va;
      b     = vb;
      @(negedge CLK);
      k     = cyc;
      start = 1'b0;
   endtask

   task automatic issue(input string name, input mdop_t op, input word_t va, input word_t vb,
                        input word_t ehi, input word_t elo);
      int   k;
      exp_t e;
      launch(op, va, vb, k);
      e.name = name;
      e.hi   = ehi;
      e.lo   = elo;
      e.cyc  = k;
      sb.push_back(e);
   endtask

   task automatic drain(input string name);
      for (int n = 0; n < 60 && sb.size() != 0; n++) @(negedge CLK);
      check({name, "_drained"}, 32'(sb.size()), 32'd0);
   endtask

   task automatic wait_done(input string name);
      for (int n = 0; n < 60 && !done; n++) @(negedge CLK);
      check({name, "_done_seen"}, done, 1'b1);
   endtask

   vec_t vecs[6] = '{
      '{"mult_neg3x5",   MD_MULT,  32'hFFFF_FFFD, 32'd5,         32'hFFFF_FFFF, 32'hFFFF_FFF1},
      '{"multu_max_sq",  MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001},
      '{"divu_100_7",    MD_DIVU,  32'd100,       32'd7,         32'd2,         32'd14},
      '{"div_neg7_2",    MD_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{"div_min_neg1",  MD_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000},
      '{"div_by_zero",   MD_DIV,   32'd123,       32'd0,         32'd123,       32'hFFFF_FFFF}
   };

   initial begin
      int k;

      repeat (2) @(negedge CLK);
      check("rst_busy", busy, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_hi", hi, 32'd0);
      check("rst_lo", lo, 32'd0);
      RST = 1'b0;

      // MULTU 7x6 with cycle-by-cycle busy profile.
      issue("multu_7x6", MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);
      check("multu_busy_1", busy, 1'b1);
      for (int j = 2; j <= RESULT_EDGES; j++) begin
         @(negedge CLK);
         check($sformatf("multu_busy_%0d", j), busy, 1'b1);
      end
      @(negedge CLK);
      check("multu_done_cycle_busy", busy, 1'b0);
      check("multu_done_cycle_done", done, 1'b1);
      @(negedge CLK);
      check("multu_done_width", done, 1'b0);
      drain("multu_7x6");

      // Directed vectors, each launched in the previous one's done cycle.
      foreach (vecs[i]) begin
         issue(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo);
         wait_done(vecs[i].name);
      end
      @(negedge CLK);
      drain("vectors");

      // MTHI / MTLO land the cycle after the write edge.
      hi_wen = 1'b1;
      wdat   = 32'h0000_00A5;
      @(negedge CLK);
      hi_wen = 1'b0;
      check("mthi", hi, 32'h0000_00A5);
      lo_wen = 1'b1;
      wdat   = 32'h0000_0055;
      @(negedge CLK);
      lo_wen = 1'b0;
      check("mtlo", lo, 32'h0000_0055);

      // Flush at start edge + 10: no result, LO keeps the MTLO value.
      launch(MD_MULT, 32'd2, 32'd3, k);
      repeat (9) @(negedge CLK);
      flush = 1'b1;
      @(negedge CLK);
      flush = 1'b0;
      check("flush_busy", busy, 1'b0);
      check("flush_done", done, 1'b0);
      check("flush_lo", lo, 32'h0000_0055);
      repeat (40) @(negedge CLK);
      check("flush_lo_later", lo, 32'h0000_0055);

      // flush together with start in IDLE: nothing launches.
      flush = 1'b1;
      launch(MD_MULTU, 32'd9, 32'd9, k);
      flush = 1'b0;
      check("flush_start_idle_busy", busy, 1'b0);

      // start and lo_wen together: the write is dropped, the product lands.
      lo_wen = 1'b1;
      wdat   = 32'h0000_0099;
      issue("start_wins_wen", MD_MULT, 32'd2, 32'd3, 32'd0, 32'd6);
      lo_wen = 1'b0;
      check("wen_dropped_lo", lo, 32'h0000_0055);
      drain("start_wins_wen");

      // Synchronous reset at start edge + 20 of a DIV discards it and clears HI/LO.
      hi_wen = 1'b1;
      wdat   = 32'h0000_1234;
      @(negedge CLK);
      hi_wen = 1'b0;
      launch(MD_DIV, 32'd1000, 32'd3, k);
      repeat (19) @(negedge CLK);
      RST = 1'b1;
      @(negedge CLK);
      RST = 1'b0;
      check("midop_rst_busy", busy, 1'b0);
      check("midop_rst_done", done, 1'b0);
      check("midop_rst_hi", hi, 32'd0);
      check("midop_rst_lo", lo, 32'd0);
      repeat (40) @(negedge CLK);
      check("midop_rst_lo_later", lo, 32'd0);

      // start while busy is ignored; the original result stands.
      issue("busy_start", MD_MULTU, 32'd7, 32'd6, 32'd0, 32'd42);
      repeat (5) @(negedge CLK);
      launch(MD_DIVU, 32'd100, 32'd7, k);
      drain("busy_start");
      repeat (40) @(negedge CLK);
      check("busy_start_final_hi", hi, 32'd0);
      check("busy_start_final_lo", lo, 32'd42);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
